// File: rtl/alu_sys_pkg.sv
// rtl/alu_sys_pkg.sv - FunSel encodings and sequencer state shared with the register bank
package alu_sys_pkg;

  localparam logic [1:0] FS_DEC  = 2'b00;
  localparam logic [1:0] FS_INC  = 2'b01;
  localparam logic [1:0] FS_LOAD = 2'b10;
  localparam logic [1:0] FS_CLR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DONE  = 2'b10
  } seq_state_t;

  // Only INC/DEC honour the repeat count; LOAD/CLR always issue once.
  function automatic logic op_uses_count(input logic [1:0] op);
    return (op == FS_DEC) || (op == FS_INC);
  endfunction

endpackage

// File: rtl/cmd_repeat_counter.sv
// rtl/cmd_repeat_counter.sv - loadable down-counter that saturates at zero, with an is-one flag
module cmd_repeat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_is_one
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_is_one = (r_count == CNT_W'(1));

endmodule

// File: rtl/reg_cmd_sequencer.sv
// rtl/reg_cmd_sequencer.sv - replays one accepted command as per-cycle E/FunSel/I pulses to a register bank
module reg_cmd_sequencer
  import alu_sys_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 16,
  parameter int CNT_W    = 8
) (
  input  logic                i_clk,
  input  logic                i_resetn,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [1:0]          i_cmd_op,
  input  logic [NUM_REGS-1:0] i_cmd_mask,
  input  logic [CNT_W-1:0]    i_cmd_count,
  input  logic [DATA_W-1:0]   i_cmd_data,
  output logic [NUM_REGS-1:0] o_reg_e,
  output logic [1:0]          o_reg_fun_sel,
  output logic [DATA_W-1:0]   o_reg_i,
  output logic                o_done
);

  seq_state_t          r_state, w_next_state;
  logic                r_cmd_ready;
  logic [NUM_REGS-1:0] r_reg_e, w_reg_e;
  logic [1:0]          r_fun_sel, w_fun_sel;
  logic [DATA_W-1:0]   r_reg_i, w_reg_i;
  logic                r_done, w_done;

  logic                w_accept;
  logic [CNT_W-1:0]    w_eff_cnt;
  logic                w_noop;
  logic                w_cnt_load;
  logic                w_cnt_dec;
  logic                w_cnt_is_one;

  assign w_accept  = i_cmd_valid && r_cmd_ready;
  assign w_eff_cnt = op_uses_count(i_cmd_op) ? i_cmd_count : CNT_W'(1);
  assign w_noop    = (w_eff_cnt == '0) || (i_cmd_mask == '0);

  cmd_repeat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .i_clk      (i_clk),
    .i_resetn   (i_resetn),
    .i_load     (w_cnt_load),
    .i_load_val (w_eff_cnt),
    .i_dec      (w_cnt_dec),
    .o_is_one   (w_cnt_is_one)
  );

  always_comb begin
    w_next_state = r_state;
    w_reg_e      = r_reg_e;
    w_fun_sel    = r_fun_sel;
    w_reg_i      = r_reg_i;
    w_done       = 1'b0;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_noop) begin
            w_next_state = ST_DONE;
            w_done       = 1'b1;
          end else begin
            w_next_state = ST_ISSUE;
            w_reg_e      = i_cmd_mask;
            w_fun_sel    = i_cmd_op;
            w_reg_i      = (i_cmd_op == FS_LOAD) ? i_cmd_data : '0;
            w_cnt_load   = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        w_cnt_dec = 1'b1;
        // The last bank operation happens on this edge, so drop E now.
        if (w_cnt_is_one) begin
          w_next_state = ST_DONE;
          w_reg_e      = '0;
          w_done       = 1'b1;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
        w_reg_e      = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_reg_e     <= '0;
      r_fun_sel   <= FS_DEC;
      r_reg_i     <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cmd_ready <= (w_next_state == ST_IDLE);
      r_reg_e     <= w_reg_e;
      r_fun_sel   <= w_fun_sel;
      r_reg_i     <= w_reg_i;
      r_done      <= w_done;
    end
  end

  assign o_cmd_ready   = r_cmd_ready;
  assign o_reg_e       = r_reg_e;
  assign o_reg_fun_sel = r_fun_sel;
  assign o_reg_i       = r_reg_i;
  assign o_done        = r_done;

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// tb/tb_reg_cmd_sequencer.sv - randomized bench with a behavioural bank and arithmetic reference model
module tb_reg_cmd_sequencer;

  logic        clk = 1'b0;
  logic        i_resetn = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [1:0]  i_cmd_op = 2'b00;
  logic [3:0]  i_cmd_mask = 4'h0;
  logic [7:0]  i_cmd_count = 8'h00;
  logic [15:0] i_cmd_data = 16'h0000;
  logic [3:0]  o_reg_e;
  logic [1:0]  o_reg_fun_sel;
  logic [15:0] o_reg_i;
  logic        o_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc = 0;

  logic [15:0] bank [4] = '{default: 16'h0000};
  logic [15:0] ref_bank [4] = '{default: 16'h0000};

  reg_cmd_sequencer #(.NUM_REGS(4), .DATA_W(16), .CNT_W(8)) dut (
    .i_clk         (clk),
    .i_resetn      (i_resetn),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_op      (i_cmd_op),
    .i_cmd_mask    (i_cmd_mask),
    .i_cmd_count   (i_cmd_count),
    .i_cmd_data    (i_cmd_data),
    .o_reg_e       (o_reg_e),
    .o_reg_fun_sel (o_reg_fun_sel),
    .o_reg_i       (o_reg_i),
    .o_done        (o_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural register bank driven by the sequencer outputs.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (o_reg_e[k]) begin
        case (o_reg_fun_sel)
          2'b00: bank[k] <= bank[k] - 16'd1;
          2'b01: bank[k] <= bank[k] + 16'd1;
          2'b10: bank[k] <= o_reg_i;
          default: bank[k] <= 16'h0000;
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (i_resetn) check("ready_while_rege", {31'd0, (o_cmd_ready && (o_reg_e != 4'h0))}, 32'd0);
  end

  task automatic ref_apply(input logic [1:0] op, input logic [3:0] mask, input logic [7:0] cnt,
                           input logic [15:0] data);
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) begin
        case (op)
          2'b00: ref_bank[k] = ref_bank[k] - 16'(cnt);
          2'b01: ref_bank[k] = ref_bank[k] + 16'(cnt);
          2'b10: ref_bank[k] = data;
          default: ref_bank[k] = 16'h0000;
        endcase
      end
    end
  endtask

  task automatic compare_bank();
    for (int k = 0; k < 4; k++) check($sformatf("bank%0d", k), 32'(bank[k]), 32'(ref_bank[k]));
  endtask

  task automatic finish_now();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Offers a command and returns just after the accepting edge, valid still high.
  task automatic start_cmd(input logic [1:0] op, input logic [3:0] mask, input logic [7:0] cnt,
                           input logic [15:0] data);
    bit got_ready;
    @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_mask  = mask;
    i_cmd_count = cnt;
    i_cmd_data  = data;
    got_ready   = 1'b0;
    for (int w = 0; w < 400; w++) begin
      if (o_cmd_ready) begin
        got_ready = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      finish_now();
    end
    @(posedge clk);
    #1;
    last_acc = cyc;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] mask, input logic [7:0] cnt,
                         input logic [15:0] data);
    int n;
    n = (op == 2'b00 || op == 2'b01) ? int'(cnt) : 1;
    if (mask == 4'h0) n = 0;
    start_cmd(op, mask, cnt, data);
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      i_cmd_valid = 1'b0;
      if (k < n) begin
        check("rege_issue", 32'(o_reg_e), 32'(mask));
        check("done_issue", 32'(o_done), 32'd0);
        check("ready_issue", 32'(o_cmd_ready), 32'd0);
        if (k == 0) begin
          check("funsel", 32'(o_reg_fun_sel), 32'(op));
          check("reg_i", 32'(o_reg_i), (op == 2'b10) ? 32'(data) : 32'd0);
        end
      end else begin
        check("rege_end", 32'(o_reg_e), 32'd0);
        check("done_pulse", 32'(o_done), 32'd1);
        check("ready_in_done", 32'(o_cmd_ready), 32'd0);
      end
    end
    @(negedge clk);
    check("ready_back", 32'(o_cmd_ready), 32'd1);
    check("done_low", 32'(o_done), 32'd0);
    ref_apply(op, mask, (op == 2'b00 || op == 2'b01) ? cnt : 8'd1, data);
    compare_bank();
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [3:0]  r_mask;
    logic [7:0]  r_cnt;
    logic [15:0] r_data;
    int t1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(o_cmd_ready), 32'd0);
    check("rst_rege", 32'(o_reg_e), 32'd0);
    check("rst_funsel", 32'(o_reg_fun_sel), 32'd0);
    check("rst_reg_i", 32'(o_reg_i), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    i_resetn = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(o_cmd_ready), 32'd1);

    run_cmd(2'b10, 4'b0001, 8'd0, 16'd5);
    run_cmd(2'b01, 4'b0001, 8'd3, 16'h1234);
    run_cmd(2'b10, 4'b1010, 8'd7, 16'hBEEF);
    run_cmd(2'b10, 4'b0001, 8'd1, 16'h0000);
    run_cmd(2'b00, 4'b0001, 8'd1, 16'h0000);
    run_cmd(2'b01, 4'b0110, 8'd0, 16'h0000);
    run_cmd(2'b11, 4'b0000, 8'd5, 16'h0000);
    run_cmd(2'b01, 4'b0100, 8'd255, 16'h0000);
    run_cmd(2'b11, 4'b0100, 8'd9, 16'h0000);

    // Reset in the middle of a ten-cycle increment: exactly four bank operations land.
    start_cmd(2'b01, 4'b1111, 8'd10, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      i_cmd_valid = 1'b0;
      check("done_pre_rst", 32'(o_done), 32'd0);
    end
    i_resetn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_mid_rege", 32'(o_reg_e), 32'd0);
      check("rst_mid_ready", 32'(o_cmd_ready), 32'd0);
      check("rst_mid_done", 32'(o_done), 32'd0);
    end
    i_resetn = 1'b1;
    @(negedge clk);
    check("ready_after_mid_rst", 32'(o_cmd_ready), 32'd1);
    check("done_after_mid_rst", 32'(o_done), 32'd0);
    ref_apply(2'b01, 4'b1111, 8'd4, 16'h0000);
    compare_bank();

    // Back-to-back with valid held high: second accept four cycles after the first.
    start_cmd(2'b01, 4'b0011, 8'd2, 16'h0000);
    t1 = last_acc;
    start_cmd(2'b01, 4'b0110, 8'd2, 16'h0000);
    check("b2b_spacing", 32'(last_acc - t1), 32'd4);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    for (int w = 0; w < 10 && !o_done; w++) @(negedge clk);
    check("b2b_done", 32'(o_done), 32'd1);
    @(negedge clk);
    ref_apply(2'b01, 4'b0011, 8'd2, 16'h0000);
    ref_apply(2'b01, 4'b0110, 8'd2, 16'h0000);
    compare_bank();

    for (int i = 0; i < 40; i++) begin
      r_op   = 2'($urandom_range(0, 3));
      r_mask = 4'($urandom_range(0, 15));
      r_cnt  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      r_data = 16'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_cmd(r_op, r_mask, r_cnt, r_data);
    end

    finish_now();
  end

endmodule
